// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
// Size codes, FSM encoding and wait-counter width.
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline-side request/result and data-memory port bundle.
// slave = the sequencer, master = MEM stage plus memory model.
interface lsu_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        bus_err;
  logic        adel;
  logic        ades;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req, we, size, sign, addr, wdata,
    input  mem_rdata, mem_ack,
    output stall, done, rdata, bus_err,
    output adel, ades,
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata
  );

  modport master (
    output req, we, size, sign, addr, wdata,
    output mem_rdata, mem_ack,
    input  stall, done, rdata, bus_err,
    input  adel, ades,
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: enables, store replication, load extract.
// Size code 3 behaves as a word access.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic       is_byte;
  logic       is_half;
  logic [7:0] b_sel;
  logic [15:0] h_sel;

  assign is_byte = (size == SZ_BYTE);
  assign is_half = (size == SZ_HALF);

  // pick the addressed byte and halfword out of the read word
  always_comb begin
    b_sel = mem_rdata[7:0];
    unique case (addr_lo)
      2'd0: b_sel = mem_rdata[7:0];
      2'd1: b_sel = mem_rdata[15:8];
      2'd2: b_sel = mem_rdata[23:16];
      2'd3: b_sel = mem_rdata[31:24];
      default: b_sel = mem_rdata[7:0];
    endcase
    h_sel = addr_lo[1] ? mem_rdata[31:16]
                       : mem_rdata[15:0];
  end

  // size decode into enables, replicated data, extended result
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = mem_rdata;
    unique case (1'b1)
      is_byte: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign & b_sel[7]}}, b_sel};
      end
      is_half: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign & h_sel[15]}}, h_sel};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between MEM stage and data memory.
// Optional alignment trap build: define LSU_ALIGN_CHECK_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       reset,
  lsu_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [1:0]       alo_q, alo_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             bus_err_q, bus_err_d;
  logic             adel_q, adel_d;
  logic             ades_q, ades_d;
  logic             done_q, done_d;

  logic             idle;
  logic             accept;
  logic             mis;
  logic [1:0]       l_size;
  logic             l_sign;
  logic [1:0]       l_alo;
  logic [3:0]       l_be;
  logic [31:0]      l_wdata;
  logic [31:0]      l_rdata;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle & bus.req;

  // lane unit sees live request in IDLE, latched one after
  assign l_size = idle ? bus.size    : size_q;
  assign l_sign = idle ? bus.sign    : sign_q;
  assign l_alo  = idle ? bus.addr[1:0] : alo_q;

  lsu_lane u_lane (
    .size      (l_size),
    .sign      (l_sign),
    .addr_lo   (l_alo),
    .wdata     (bus.wdata),
    .mem_rdata (bus.mem_rdata),
    .be        (l_be),
    .wdata_rep (l_wdata),
    .rdata_ext (l_rdata)
  );

`ifdef LSU_ALIGN_CHECK_EN
  logic is_word;
  assign is_word = (bus.size == SZ_WORD) |
                   (bus.size == 2'd3);
  assign mis = ((bus.size == SZ_HALF) & bus.addr[0]) |
               (is_word & (|bus.addr[1:0]));
`else
  assign mis = 1'b0;
`endif

  // next-state, request latch, memory drive and result capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    sign_d      = sign_q;
    alo_d       = alo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    bus_err_d   = bus_err_q;
    adel_d      = adel_q;
    ades_d      = ades_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d      = bus.we;
          size_d    = bus.size;
          sign_d    = bus.sign;
          alo_d     = bus.addr[1:0];
          cnt_d     = '0;
          rdata_d   = '0;
          bus_err_d = 1'b0;
          adel_d    = 1'b0;
          ades_d    = 1'b0;
          if (mis) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            adel_d  = ~bus.we;
            ades_d  = bus.we;
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.we;
            mem_be_d    = l_be;
            mem_addr_d  = {bus.addr[31:2], 2'b00};
            mem_wdata_d = l_wdata;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_ack || cnt_q == TMO_LAST) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (bus.mem_ack) begin
            rdata_d = we_q ? 32'd0 : l_rdata;
          end else begin
            rdata_d   = '0;
            bus_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_WORD;
      sign_q      <= 1'b0;
      alo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      alo_q       <= alo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      adel_q      <= adel_d;
      ades_q      <= ades_d;
      done_q      <= done_d;
    end
  end

  assign bus.stall     = accept | (state_q == ST_REQ);
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.adel      = adel_q;
  assign bus.ades      = ades_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed vector bench for lsu_ctrl with TIMEOUT=4.
// Honours LSU_ALIGN_CHECK_EN for the misaligned cases.
module tb_lsu_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          ack_at;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] maddr;
    logic [31:0] rdata;
    logic        err;
    logic        adel;
    logic        ades;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int cyc;
    int reqn;
    int stl;
    int nreq;
    bit got;
    string p;
    p = $sformatf("v%0d", idx);
    bus.req       = 1'b1;
    bus.we        = v.we;
    bus.size      = v.size;
    bus.sign      = v.sign;
    bus.addr      = v.addr;
    bus.wdata     = v.wdata;
    bus.mem_rdata = v.rd;
    bus.mem_ack   = 1'b0;
    #1;
    stl  = bus.stall ? 1 : 0;
    cyc  = 0;
    reqn = 0;
    nreq = 0;
    got  = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.stall) stl++;
        if (bus.mem_req) nreq++;
        check({p, "_maddr"}, bus.mem_addr, v.maddr);
        check({p, "_be"}, {28'd0, bus.mem_be},
              {28'd0, v.be});
        check({p, "_mwdata"}, bus.mem_wdata, v.mwd);
        check({p, "_mwe"}, {31'd0, bus.mem_we},
              {31'd0, v.we});
        bus.mem_ack = (reqn == v.ack_at);
        reqn++;
      end
    end
    bus.mem_ack = 1'b0;
    check({p, "_latency"}, cyc, v.lat);
    check({p, "_rdata"}, bus.rdata, v.rdata);
    check({p, "_bus_err"}, {31'd0, bus.bus_err},
          {31'd0, v.err});
    check({p, "_adel"}, {31'd0, bus.adel},
          {31'd0, v.adel});
    check({p, "_ades"}, {31'd0, bus.ades},
          {31'd0, v.ades});
    check({p, "_done_stall"}, {31'd0, bus.stall}, 32'd0);
    check({p, "_done_mreq"}, {31'd0, bus.mem_req}, 32'd0);
    check({p, "_nreq"}, nreq, v.lat - 1);
    check({p, "_stall_cyc"}, stl, v.lat);
    bus.req = 1'b0;
    @(negedge clk);
    check({p, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({p, "_rdata_hold"}, bus.rdata, v.rdata);
  endtask

  task automatic check_zero(input string p);
    check({p, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    check({p, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    check({p, "_mem_be"}, {28'd0, bus.mem_be}, 32'd0);
    check({p, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({p, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({p, "_rdata"}, bus.rdata, 32'd0);
    check({p, "_done"}, {31'd0, bus.done}, 32'd0);
    check({p, "_bus_err"}, {31'd0, bus.bus_err}, 32'd0);
    check({p, "_adel"}, {31'd0, bus.adel}, 32'd0);
    check({p, "_ades"}, {31'd0, bus.ades}, 32'd0);
    check({p, "_stall"}, {31'd0, bus.stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    // we sz sg addr wdata rd ack be mwd maddr rdata e l s lat
    vq.push_back('{1'b0, 2'd2, 1'b1, 32'h1003, 32'h0,
      32'h80FF1234, 0, 4'b1000, 32'h0, 32'h1000,
      32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 2});
    vq.push_back('{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0,
      32'hBEEF0000, 2, 4'b1100, 32'h0, 32'h2000,
      32'h0000BEEF, 1'b0, 1'b0, 1'b0, 4});
    vq.push_back('{1'b1, 2'd2, 1'b0, 32'h11, 32'hA5,
      32'hDEADBEEF, 0, 4'b0010, 32'hA5A5A5A5, 32'h10,
      32'h0, 1'b0, 1'b0, 1'b0, 2});
    vq.push_back('{1'b0, 2'd0, 1'b0, 32'h4000, 32'h0,
      32'h12345678, 255, 4'b1111, 32'h0, 32'h4000,
      32'h0, 1'b1, 1'b0, 1'b0, 5});
    vq.push_back('{1'b0, 2'd0, 1'b0, 32'h4000, 32'h0,
      32'h12345678, 3, 4'b1111, 32'h0, 32'h4000,
      32'h12345678, 1'b0, 1'b0, 1'b0, 5});
    vq.push_back('{1'b0, 2'd1, 1'b1, 32'h5000, 32'h0,
      32'h12348001, 1, 4'b0011, 32'h0, 32'h5000,
      32'hFFFF8001, 1'b0, 1'b0, 1'b0, 3});
    vq.push_back('{1'b1, 2'd1, 1'b0, 32'h6002, 32'hFFFF1234,
      32'h0, 0, 4'b1100, 32'h12341234, 32'h6000,
      32'h0, 1'b0, 1'b0, 1'b0, 2});
    vq.push_back('{1'b1, 2'd0, 1'b0, 32'h7000, 32'hCAFEF00D,
      32'h0, 0, 4'b1111, 32'hCAFEF00D, 32'h7000,
      32'h0, 1'b0, 1'b0, 1'b0, 2});
    vq.push_back('{1'b0, 2'd2, 1'b0, 32'h8001, 32'h0,
      32'h00009A00, 0, 4'b0010, 32'h0, 32'h8000,
      32'h0000009A, 1'b0, 1'b0, 1'b0, 2});
    vq.push_back('{1'b0, 2'd3, 1'b1, 32'h9000, 32'h0,
      32'h89ABCDEF, 0, 4'b1111, 32'h0, 32'h9000,
      32'h89ABCDEF, 1'b0, 1'b0, 1'b0, 2});
`ifdef LSU_ALIGN_CHECK_EN
    vq.push_back('{1'b0, 2'd0, 1'b0, 32'h3002, 32'h0,
      32'h11223344, 0, 4'b0000, 32'h0, 32'h0,
      32'h0, 1'b0, 1'b1, 1'b0, 1});
    vq.push_back('{1'b1, 2'd1, 1'b0, 32'h3001, 32'h5678,
      32'h0, 0, 4'b0000, 32'h0, 32'h0,
      32'h0, 1'b0, 1'b0, 1'b1, 1});
`else
    vq.push_back('{1'b0, 2'd0, 1'b0, 32'h3002, 32'h0,
      32'h11223344, 0, 4'b1111, 32'h0, 32'h3000,
      32'h11223344, 1'b0, 1'b0, 1'b0, 2});
    vq.push_back('{1'b1, 2'd1, 1'b0, 32'h3001, 32'h5678,
      32'h0, 0, 4'b0011, 32'h56785678, 32'h3000,
      32'h0, 1'b0, 1'b0, 1'b0, 2});
`endif

    reset         = 1'b1;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.size      = 2'd0;
    bus.sign      = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      run(vq[i], i);
    end

    // reset while the memory access is outstanding
    bus.req   = 1'b1;
    bus.we    = 1'b0;
    bus.size  = 2'd0;
    bus.sign  = 1'b0;
    bus.addr  = 32'hA000;
    @(negedge clk);
    check("mid_mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("mid_mem_addr", bus.mem_addr, 32'hA000);
    reset   = 1'b1;
    bus.req = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    reset = 1'b0;
    @(negedge clk);
    check_zero("postrst");
    run(vq[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
